// File: rtl/bcd_seq_code_converter.sv
// bcd_seq_code_converter
//   Sequential binary-to-decimal code converter. A BIN_W-bit unsigned word is
//   turned into DIGITS decimal digits by shift-and-add-3, one input bit per
//   clock. Each digit is then encoded in a run-time selected 4-bit decimal
//   code: 8421, excess-3, 2421 (Aiken) or Gray.
//
// Handshake: a word moves across an interface on a rising edge where both
//   valid and ready are high. Upstream: in_valid/in_ready, with din and mode
//   sampled on that edge. Downstream: out_valid/out_ready, with dout and
//   overflow held stable while out_valid is high and not yet accepted.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   din/mode valid
//   in_ready   converter idle, a word can be accepted
//   din        unsigned binary input word
//   mode       00=8421, 01=excess-3, 10=2421, 11=Gray
//   out_valid  dout/overflow valid
//   out_ready  downstream accepts dout
//   dout       encoded digits, units digit in dout[3:0]
//   overflow   din >= 10**DIGITS (dout then holds the low DIGITS digits)
//
// FSM: IDLE -> SHIFT (BIN_W edges) -> ENCODE (1 edge) -> HOLD -> IDLE.
//   The current state is visible as the internal signal 'state'.
module bcd_seq_code_converter #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      din,
  input  logic [1:0]            mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   dout,
  output logic                  overflow
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_ENCODE = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  logic [1:0]       state;
  logic [BIN_W-1:0] sh;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] adj;
  logic [ACC_W-1:0] enc;
  logic [1:0]       mode_r;
  logic [CNT_W-1:0] cnt;

  function automatic logic [3:0] encode_digit(input logic [3:0] d, input logic [1:0] m);
    logic [3:0] r;
    case (m)
      2'b00:   r = d;
      2'b01:   r = d + 4'd3;
      2'b10:   r = (d < 4'd5) ? d : d + 4'd6;
      default: r = d ^ (d >> 1);
    endcase
    return r;
  endfunction

  // Add-3 correction and output encoding, digit by digit. Digits never exceed
  // 9 before correction, so +3 stays within 4 bits; the digit MSB then carries
  // into the next digit through the left shift.
  always_comb begin
    adj = '0;
    enc = '0;
    for (int k = 0; k < DIGITS; k++) begin
      adj[4*k +: 4] = (acc[4*k +: 4] >= 4'd5) ? acc[4*k +: 4] + 4'd3 : acc[4*k +: 4];
      enc[4*k +: 4] = encode_digit(acc[4*k +: 4], mode_r);
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      sh       <= '0;
      acc      <= '0;
      mode_r   <= 2'b00;
      cnt      <= '0;
      dout     <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            sh       <= din;
            mode_r   <= mode;
            acc      <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
            state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          acc <= {adj[ACC_W-2:0], sh[BIN_W-1]};
          sh  <= sh << 1;
          // A carry out of the top digit means the value no longer fits in
          // DIGITS decimal digits; the lower digits remain correct.
          if (adj[ACC_W-1]) overflow <= 1'b1;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(BIN_W - 1)) state <= S_ENCODE;
        end
        S_ENCODE: begin
          dout  <= enc;
          state <= S_HOLD;
        end
        default: begin
          if (out_ready) state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seq_code_converter.sv
// Bench for bcd_seq_code_converter: one 8-bit and one 10-bit instance (both
// 3 digits), directed cases plus randomized words checked against a decimal
// reference model.
module tb_bcd_seq_code_converter;

  logic clk;
  logic rst_n;

  // 8-bit instance
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_overflow;
  logic [7:0]  a_din;
  logic [1:0]  a_mode;
  logic [11:0] a_dout;

  // 10-bit instance
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_overflow;
  logic [9:0]  b_din;
  logic [1:0]  b_mode;
  logic [11:0] b_dout;

  int n_tests = 0;
  int n_fail  = 0;

  bcd_seq_code_converter #(.BIN_W(8), .DIGITS(3)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .din(a_din), .mode(a_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .dout(a_dout), .overflow(a_overflow)
  );

  bcd_seq_code_converter #(.BIN_W(10), .DIGITS(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .din(b_din), .mode(b_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .dout(b_dout), .overflow(b_overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: decimal digits by division, then the code table.
  task automatic model(input int unsigned v, input logic [1:0] m,
                       output logic [11:0] d, output logic o);
    int unsigned q;
    int unsigned dig;
    int unsigned code;
    o = (v >= 1000);
    q = v;
    d = '0;
    for (int k = 0; k < 3; k++) begin
      dig = q % 10;
      q   = q / 10;
      case (m)
        2'b00:   code = dig;
        2'b01:   code = dig + 3;
        2'b10:   code = (dig < 5) ? dig : dig + 6;
        default: code = dig ^ (dig >> 1);
      endcase
      d[4*k +: 4] = code[3:0];
    end
  endtask

  // Drive one word into the selected instance, check latency and result,
  // stall downstream for hold_cycles (with a competing in_valid), then hand off.
  task automatic do_conv(input bit wide, input int unsigned val, input logic [1:0] m,
                         input int hold_cycles, input string tag);
    logic [11:0] exp_d;
    logic        exp_o;
    int          n;
    int          bw;
    logic [9:0]  v10;
    bw  = wide ? 10 : 8;
    v10 = val[9:0];
    model(wide ? val : (val & 32'hFF), m, exp_d, exp_o);
    if (wide) begin b_din = v10; b_mode = m; b_in_valid = 1'b1; end
    else begin a_din = v10[7:0]; a_mode = m; a_in_valid = 1'b1; end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    // scramble inputs after accept; they must not affect the conversion
    a_din = 8'($urandom); b_din = 10'($urandom); a_mode = 2'($urandom); b_mode = 2'($urandom);
    check({tag, "/in_ready_busy"}, 32'(wide ? b_in_ready : a_in_ready), 32'd0);
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (wide ? b_out_valid : a_out_valid) break;
    end
    check({tag, "/latency"}, n, bw + 1);
    check({tag, "/dout"}, 32'(wide ? b_dout : a_dout), 32'(exp_d));
    check({tag, "/overflow"}, 32'(wide ? b_overflow : a_overflow), 32'(exp_o));
    for (int i = 0; i < hold_cycles; i++) begin
      if (wide) begin b_in_valid = 1'b1; b_din = ~v10; end
      else begin a_in_valid = 1'b1; a_din = ~v10[7:0]; end
      @(posedge clk); #1;
      check({tag, "/hold_valid"}, 32'(wide ? b_out_valid : a_out_valid), 32'd1);
      check({tag, "/hold_dout"}, 32'(wide ? b_dout : a_dout), 32'(exp_d));
      check({tag, "/hold_in_ready"}, 32'(wide ? b_in_ready : a_in_ready), 32'd0);
    end
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    if (wide) b_out_ready = 1'b1; else a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    b_out_ready = 1'b0;
    check({tag, "/handoff_valid"}, 32'(wide ? b_out_valid : a_out_valid), 32'd0);
    check({tag, "/handoff_in_ready"}, 32'(wide ? b_in_ready : a_in_ready), 32'd1);
    check({tag, "/idle_dout"}, 32'(wide ? b_dout : a_dout), 32'(exp_d));
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_din = '0; a_mode = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_din = '0; b_mode = '0;
    #3;
    check("reset/a_in_ready", 32'(a_in_ready), 32'd1);
    check("reset/a_out_valid", 32'(a_out_valid), 32'd0);
    check("reset/a_dout", 32'(a_dout), 32'd0);
    check("reset/a_overflow", 32'(a_overflow), 32'd0);
    check("reset/b_in_ready", 32'(b_in_ready), 32'd1);
    check("reset/b_out_valid", 32'(b_out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // directed: all four codes of 157, boundaries, long stall
    do_conv(1'b0, 157, 2'b00, 0,  "d157_8421");
    do_conv(1'b0, 157, 2'b01, 1,  "d157_xs3");
    do_conv(1'b0, 157, 2'b10, 0,  "d157_2421");
    do_conv(1'b0, 157, 2'b11, 2,  "d157_gray");
    do_conv(1'b0, 0,   2'b01, 0,  "d0_xs3");
    do_conv(1'b0, 255, 2'b00, 0,  "d255_8421");
    do_conv(1'b0, 157, 2'b00, 20, "stall20");

    // asynchronous reset mid-SHIFT
    a_din = 8'd200; a_mode = 2'b00; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("areset/in_ready", 32'(a_in_ready), 32'd1);
    check("areset/out_valid", 32'(a_out_valid), 32'd0);
    check("areset/dout", 32'(a_dout), 32'd0);
    check("areset/overflow", 32'(a_overflow), 32'd0);
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    do_conv(1'b0, 42, 2'b00, 0, "after_reset_42");

    // 10-bit instance: overflow boundaries and sticky-flag clearing
    do_conv(1'b1, 999,  2'b00, 0, "w999");
    do_conv(1'b1, 1000, 2'b00, 0, "w1000");
    do_conv(1'b1, 1023, 2'b00, 1, "w1023");
    do_conv(1'b1, 999,  2'b01, 0, "w999_xs3");

    // randomized words on both instances
    for (int i = 0; i < 40; i++) begin
      bit          wide;
      int unsigned v;
      wide = 1'($urandom_range(0, 1));
      v    = wide ? $urandom_range(0, 1023) : $urandom_range(0, 255);
      do_conv(wide, v, 2'($urandom_range(0, 3)), $urandom_range(0, 3), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
